conv3x3_mac_engine: RTL and testbench

- 3x3 convolution datapath that sits directly downstream of the line-buffer window controller.
- Each valid cycle it consumes one 72-bit window (nine 8-bit unsigned pixels) and produces one 8-bit filtered pixel after a fixed 3-cycle pipeline.
- Coefficients are programmable: writes go to a shadow bank, and a commit copies the shadow bank to the active bank only at a line boundary, so a line never mixes kernels.
- It also emits an end-of-line pulse for the downstream output/DMA stage.

---
 rtl/conv3x3_mac_engine.sv | 120 ++++++++++++
 tb/tb_conv3x3_mac_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac_engine.sv
// conv3x3_mac_engine: 3-stage 3x3 convolution MAC with a shadow/active coefficient bank
// whose commit is deferred to the next line boundary so a line never mixes kernels.
module conv3x3_mac_engine #(
    parameter int LINE_W = 512,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [9*PIX_W-1:0]   i_pixel_data,
    input  logic                 i_pixel_data_valid,
    input  logic                 i_coef_we,
    input  logic [3:0]           i_coef_addr,
    input  logic [COEF_W-1:0]    i_coef_data,
    input  logic [3:0]           i_shift,
    input  logic                 i_commit,
    output logic [PIX_W-1:0]     o_convolved_data,
    output logic                 o_convolved_data_valid,
    output logic                 o_line_done,
    output logic                 o_commit_pending
);
    localparam int PW = PIX_W + COEF_W + 1;
    localparam int SW = PW + 4;
    localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;

    logic signed [COEF_W-1:0] sh_coef [9];
    logic signed [COEF_W-1:0] act_coef [9];
    logic [3:0] act_shift, shift1, shift2;
    logic pend, req, apply;
    logic [CW-1:0] in_pos, out_pos;
    logic v1, v2;
    logic signed [PW-1:0] px [9];
    logic signed [PW-1:0] cx [9];
    logic signed [PW-1:0] prod_d [9];
    logic signed [PW-1:0] prod [9];
    logic signed [SW-1:0] sum_d, sum, shifted;
    logic [PIX_W-1:0] sat;

    assign req              = pend | i_commit;
    assign apply            = req && (in_pos == '0) && !i_pixel_data_valid;
    assign o_commit_pending = pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 9; k++) sh_coef[k] <= (k == 4) ? COEF_W'(1) : '0;
        end else if (i_coef_we) begin
            for (int k = 0; k < 9; k++)
                if (i_coef_addr == 4'(k)) sh_coef[k] <= i_coef_data;
        end
    end

    // Apply samples the shadow bank before this cycle's write lands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 9; k++) act_coef[k] <= (k == 4) ? COEF_W'(1) : '0;
            act_shift <= '0;
            pend      <= 1'b0;
        end else begin
            pend <= req && !apply;
            if (apply) begin
                act_coef  <= sh_coef;
                act_shift <= i_shift;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            in_pos <= '0;
        else if (i_pixel_data_valid)
            in_pos <= (in_pos == CW'(LINE_W - 1)) ? '0 : in_pos + 1'b1;
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < 9; k++) begin
            px[k]     = PW'(i_pixel_data[PIX_W*k +: PIX_W]);
            cx[k]     = PW'(act_coef[k]);
            prod_d[k] = px[k] * cx[k];
            sum_d     = sum_d + SW'(prod[k]);
        end
    end

    assign shifted = sum >>> shift2;
    assign sat     = (shifted < 0) ? '0 :
                     (shifted > SW'((1 << PIX_W) - 1)) ? {PIX_W{1'b1}} : shifted[PIX_W-1:0];

    // The shift travels with each window so the last pixels of a line keep their kernel's shift.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 9; k++) prod[k] <= '0;
            sum                    <= '0;
            shift1                 <= '0;
            shift2                 <= '0;
            v1                     <= 1'b0;
            v2                     <= 1'b0;
            o_convolved_data_valid <= 1'b0;
            o_convolved_data       <= '0;
            o_line_done            <= 1'b0;
            out_pos                <= '0;
        end else begin
            v1                     <= i_pixel_data_valid;
            v2                     <= v1;
            o_convolved_data_valid <= v2;
            o_line_done            <= v2 && (out_pos == CW'(LINE_W - 1));
            if (i_pixel_data_valid) begin
                prod   <= prod_d;
                shift1 <= act_shift;
            end
            if (v1) begin
                sum    <= sum_d;
                shift2 <= shift1;
            end
            if (v2) begin
                o_convolved_data <= sat;
                out_pos          <= (out_pos == CW'(LINE_W - 1)) ? '0 : out_pos + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_mac_engine.sv
// tb_conv3x3_mac_engine: randomized bench for conv3x3_mac_engine against a
// cycle-level reference model of kernels, commits, latency and line pulses.
module tb_conv3x3_mac_engine;
    localparam int LINE_W = 512;

    logic        clk, rst_n;
    logic [71:0] data;
    logic        valid, we, commit;
    logic [3:0]  addr, shift;
    logic [7:0]  cdata;
    logic [7:0]  o_data;
    logic        o_valid, o_ld, o_pend;

    conv3x3_mac_engine #(.LINE_W(LINE_W), .PIX_W(8), .COEF_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(data), .i_pixel_data_valid(valid),
        .i_coef_we(we), .i_coef_addr(addr), .i_coef_data(cdata), .i_shift(shift),
        .i_commit(commit), .o_convolved_data(o_data), .o_convolved_data_valid(o_valid),
        .o_line_done(o_ld), .o_commit_pending(o_pend)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int errors, checks;
    int m_sh[9];
    int m_act[9];
    int m_shift, m_inpos, m_outpos, m_last;
    bit m_pend;
    bit dv[3];
    int dd[3];
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];

    task automatic model_init();
        for (int k = 0; k < 9; k++) begin
            m_sh[k]  = (k == 4) ? 1 : 0;
            m_act[k] = (k == 4) ? 1 : 0;
        end
        for (int k = 0; k < 3; k++) begin
            dv[k] = 0;
            dd[k] = 0;
        end
        m_shift = 0; m_pend = 0; m_inpos = 0; m_outpos = 0; m_last = 0;
    endtask

    function automatic int conv(logic [71:0] w);
        int acc = 0;
        for (int k = 0; k < 9; k++) acc += int'(w[8*k +: 8]) * m_act[k];
        acc = acc >>> m_shift;
        if (acc < 0) return 0;
        if (acc > 255) return 255;
        return acc;
    endfunction

    function automatic logic [71:0] rnd_win();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic tick();
        bit req, app, ev, ld;
        int ed;
        @(posedge clk);
        ev  = valid;
        ed  = valid ? conv(data) : 0;
        req = m_pend || commit;
        app = req && m_inpos == 0 && !valid;
        if (app) begin
            for (int k = 0; k < 9; k++) m_act[k] = m_sh[k];
            m_shift = int'(shift);
        end
        m_pend = req && !app;
        if (we && addr <= 8) m_sh[addr] = int'($signed(cdata));
        if (valid) m_inpos = (m_inpos + 1) % LINE_W;
        dv[2] = dv[1]; dd[2] = dd[1];
        dv[1] = dv[0]; dd[1] = dd[0];
        dv[0] = ev;    dd[0] = ed;
        ld = 0;
        if (dv[2]) begin
            m_last = dd[2];
            m_outpos++;
            if (m_outpos == LINE_W) begin
                m_outpos = 0;
                ld = 1;
            end
        end
        #1;
        obs_q.push_back({o_valid, o_ld, o_pend, o_data});
        exp_q.push_back({dv[2], ld, m_pend, 8'(m_last)});
    endtask

    task automatic idle(int n);
        valid = 0; we = 0; commit = 0;
        repeat (n) tick();
    endtask

    task automatic win(logic [71:0] w);
        valid = 1; data = w;
        tick();
        valid = 0;
    endtask

    task automatic wr(int a, int v);
        we = 1; addr = 4'(a); cdata = 8'(v);
        tick();
        we = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; valid = 0; we = 0; commit = 0; addr = 0; cdata = 0; shift = 0; data = 0;
        repeat (2) @(posedge clk);
        model_init();
        @(negedge clk);
        rst_n = 1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", o_data); end
        checks++; if (o_ld !== 1'b0) begin errors++; $display("FAIL reset_line_done got %b want 0", o_ld); end
        checks++; if (o_pend !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", o_pend); end
    endtask

    task automatic test_identity();
        logic [71:0] w;
        int nv;
        do_reset();
        w = 72'h99_88_77_66_5A_44_33_22_11;
        win(w);
        idle(4);
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL identity cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        nv = 0;
        foreach (obs_q[i]) nv += int'(obs_q[i][10]);
        checks++; if (nv != 1) begin errors++; $display("FAIL identity_valid_count got %0d want 1", nv); end
        checks++; if (obs_q[2] !== 11'h45A) begin errors++; $display("FAIL identity_latency got %h want 45a", obs_q[2]); end
    endtask

    task automatic test_box();
        int vals[$];
        do_reset();
        for (int k = 0; k < 9; k++) wr(k, 1);
        for (int a = 9; a < 16; a++) wr(a, 8'h55);
        shift = 4'd3; commit = 1;
        tick();
        commit = 0; shift = 4'd0;
        win({9{8'h10}});
        win({9{8'hFF}});
        idle(4);
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL box cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][10]) vals.push_back(int'(obs_q[i][7:0]));
        end
        checks++;
        if (vals.size() != 2 || vals[0] != 'h12 || vals[1] != 'hFF) begin
            errors++; $display("FAIL box_values got n=%0d %p want 18,255", vals.size(), vals);
        end
    endtask

    task automatic test_laplacian();
        int vals[$];
        do_reset();
        for (int k = 0; k < 9; k++) wr(k, (k == 4) ? 8 : -1);
        commit = 1;
        tick();
        commit = 0;
        win({9{8'd100}});
        win(72'h00_00_00_00_C8_00_00_00_00);
        win(72'hFF_FF_FF_FF_00_FF_FF_FF_FF);
        idle(4);
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL laplacian cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
            if (obs_q[i][10]) vals.push_back(int'(obs_q[i][7:0]));
        end
        checks++;
        if (vals.size() != 3 || vals[0] != 0 || vals[1] != 255 || vals[2] != 0) begin
            errors++; $display("FAIL laplacian_values got n=%0d %p want 0,255,0", vals.size(), vals);
        end
    endtask

    task automatic test_deferred();
        int hi;
        do_reset();
        for (int k = 0; k < 9; k++) wr(k, $urandom_range(0, 8) - 4);
        shift = 4'($urandom_range(0, 2));
        for (int i = 0; i < LINE_W; i++) begin
            valid = 1; data = rnd_win(); commit = (i == 100 || i == 300);
            tick();
        end
        valid = 0; commit = 0;
        wr(0, $urandom_range(0, 8) - 4);
        shift = 4'd0;
        for (int i = 0; i < 40; i++) win(rnd_win());
        idle(4);
        hi = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL deferred cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
            hi += int'(obs_q[i][8]);
        end
        checks++; if (hi != LINE_W - 100) begin errors++; $display("FAIL deferred_pending_cycles got %0d want %0d", hi, LINE_W - 100); end
    endtask

    task automatic test_line_done();
        int pulses;
        do_reset();
        for (int i = 0; i < 2 * LINE_W; i++) begin
            win(rnd_win());
            idle($urandom_range(1, 3));
        end
        idle(4);
        pulses = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL line_done cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
            pulses += int'(obs_q[i][9]);
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL line_done_pulses got %0d want 2", pulses); end
    endtask

    task automatic test_async_reset();
        int nv;
        logic [71:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w = rnd_win();
            w[39:32] = 8'hA5;
            valid = 1; data = w; commit = (i == 1);
            tick();
        end
        valid = 0; commit = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL pre_reset cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        #3 rst_n = 0;
        #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", o_valid); end
        checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL async_data got %h want 00", o_data); end
        checks++; if (o_pend !== 1'b0) begin errors++; $display("FAIL async_pending got %b want 0", o_pend); end
        repeat (2) @(posedge clk);
        model_init();
        @(negedge clk);
        rst_n = 1;
        obs_q.delete();
        exp_q.delete();
        idle(5);
        win(72'h01_02_03_04_C3_06_07_08_09);
        idle(4);
        nv = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL post_reset cyc %0d got %h want %h", i, obs_q[i], exp_q[i]); end
            nv += int'(obs_q[i][10]);
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL post_reset_valid_count got %0d want 1", nv); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0; checks = 0;
        rst_n = 0; valid = 0; we = 0; commit = 0; addr = 0; cdata = 0; shift = 0; data = 0;
        test_reset();
        test_identity();
        test_box();
        test_laplacian();
        test_deferred();
        test_line_done();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
